mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: the number of consecutive cycles the port may stay not-ready before the watchdog fires.
REQ-002 SHALL have ports, in this order:
- clk: in, 1 bit, rising-edge clock.
- rst: in, 1 bit, synchronous active-high reset.
REQ-003 if_req  in  1  instruction-fetch request; held until if_done.
REQ-004 if_addr  in  32  fetch address; stable while if_req is high.
REQ-005 mem_req  in  1  data-access request from the MEM stage; held until mem_done.
REQ-006 mem_we  in  1  data write enable; stable while mem_req is high.
REQ-007 mem_addr, mem_wdata  in  32 each  data address and write data; stable while mem_req is high.
REQ-008 port_ready  in  1  the memory completes the current access this cycle.
REQ-009 port_rdata  in  32  memory read data; valid when port_ready is high.
REQ-010 port_sel  out  1  select for the shared 32-bit address mux: 0 = IF, 1 = MEM.
REQ-011 port_valid, port_we  out  1 each  access active; write strobe.
REQ-012 port_addr, port_wdata  out  32 each  selected address; mem_wdata.
REQ-013 if_done, mem_done  out  1 each  one-cycle completion pulses.
REQ-014 rd_data  out  32  port_rdata passthrough.
REQ-015 stall_if, stall_mem  out  1 each  pipeline stall requests.
REQ-016 err  out  1  sticky watchdog error flag.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY_I, BUSY_D and ERR; ERR is present only when the macro in REQ-032 is defined.
REQ-018 In IDLE, the FSM SHALL move to BUSY_D when mem_req=1 and either if_req=0 or last_grant=IF.
- Otherwise it SHALL move to BUSY_I when if_req=1.
- Otherwise it SHALL stay in IDLE.
REQ-019 last_grant SHALL be a 1-bit register updated on every transition into BUSY_x; this gives round-robin arbitration under contention.
REQ-020 port_sel SHALL be registered: it loads 1 on entry to BUSY_D, loads 0 on entry to BUSY_I, and holds its value otherwise.
REQ-021 port_addr SHALL equal mem_addr when port_sel=1 and if_addr when port_sel=0, combinationally.
REQ-022 port_valid SHALL be 1 exactly in BUSY_I and BUSY_D.
- port_we SHALL be 1 only in BUSY_D and only when mem_we=1.
REQ-023 if_done SHALL equal (state==BUSY_I) AND port_ready; mem_done SHALL equal (state==BUSY_D) AND port_ready. Both are combinational.
- On a done pulse, the FSM SHALL return to IDLE.
REQ-024 Latency: a request seen in IDLE at cycle N SHALL give port_valid at N+1.
- The earliest done pulse is at N+1.
- Back-to-back grants SHALL include one IDLE cycle between them.
REQ-025 Deasserting a request while its access is in BUSY SHALL be ignored: the access runs to port_ready.
REQ-026 stall_if SHALL equal if_req AND NOT if_done; stall_mem SHALL equal mem_req AND NOT mem_done.
REQ-027 port_ready SHALL be ignored in IDLE and ERR.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL load:
- state=IDLE
- last_grant=IF (so MEM wins the first contention)
- port_sel=0
- watchdog count=0
- err=0
REQ-029 Reset SHALL take priority over every other transition, including mid-access.
- port_valid SHALL be 0 in the cycle after the reset edge.
- No done pulse SHALL be issued for an aborted access.
REQ-030 While rst is held, all outputs SHALL be 0 except the combinational passthroughs rd_data, port_addr and port_wdata.

Configuration
REQ-031 The block SHALL have exactly one compile-time option.
REQ-032 With MEM_PORT_ARB_TIMEOUT_EN defined, the watchdog SHALL be built as follows:
- A counter clears on entry to BUSY_x.
- It increments on each BUSY cycle with port_ready=0.
- When it reaches TIMEOUT_CYCLES with port_ready still 0, the FSM SHALL go to ERR.
- In ERR: err=1, port_valid=0, no further grants, no done pulses, and stall_if/stall_mem follow their requests.
- Only rst SHALL leave ERR.
REQ-033 Without MEM_PORT_ARB_TIMEOUT_EN, the block SHALL have no counter and no ERR state, err SHALL be tied to 0, and BUSY SHALL wait indefinitely.

Verification
REQ-034 Single fetch:
- Stimulus: if_req=1, if_addr=0x00000040, port_ready=1 from cycle 1, port_rdata=0xDEADBEEF.
- Response: port_sel=0, port_valid=1 at cycle 1; if_done=1 and rd_data=0xDEADBEEF at cycle 1.
REQ-035 Contention after reset:
- Stimulus: if_req=1 and mem_req=1 at cycle 0, port_ready=1 always.
- Response: MEM served first (port_sel=1, mem_done at cycle 1), then IDLE at cycle 2, then IF served with if_done at cycle 3.
REQ-036 Write with wait states:
- Stimulus: mem_req=1, mem_we=1, mem_addr=0x100, mem_wdata=0x12345678; port_ready low for 3 cycles, then high.
- Response: port_we=1 and stall_mem=1 throughout; exactly one mem_done, at cycle 4.
REQ-037 Reset mid-access:
- Stimulus: rst=1 during BUSY_D.
- Response: next cycle port_valid=0, no mem_done; with both requests pending afterwards, MEM is granted first.
REQ-038 Watchdog (with the macro defined, TIMEOUT_CYCLES=4):
- Stimulus: fetch granted, port_ready=0 forever.
- Response: err=1 and port_valid=0 after 4 BUSY cycles; a later mem_req gets no grant until rst.
- Same stimulus without the macro: port_valid stays 1 and err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between
// instruction fetch (IF) and data access (MEM). One access in flight at a time.
// Optional watchdog: define MEM_PORT_ARB_TIMEOUT_EN to build the timeout
// counter and the sticky ERR state; otherwise BUSY waits indefinitely.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        port_ready,
    input  logic [31:0] port_rdata,
    output logic        port_sel,
    output logic        port_valid,
    output logic        port_we,
    output logic [31:0] port_addr,
    output logic [31:0] port_wdata,
    output logic        if_done,
    output logic        mem_done,
    output logic [31:0] rd_data,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err
);

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ERR} state_t;
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q;
    logic            err_q;
`else
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
`endif

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    state_t state_q;
    logic   last_grant_q;
    logic   sel_q;
    logic   valid_q;

    logic   grant_mem;
    logic   grant_if;
    logic   busy_i;
    logic   busy_d;

    // MEM wins when IF is idle or IF had the previous grant.
    assign grant_mem = mem_req & (~if_req | (last_grant_q == GRANT_IF));
    assign grant_if  = if_req & ~grant_mem;
    assign busy_i    = (state_q == BUSY_I);
    assign busy_d    = (state_q == BUSY_D);

    // Arbitration FSM with registered select/valid, grant history and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IF;
            sel_q        <= 1'b0;
            valid_q      <= 1'b0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
            wd_cnt_q     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_mem) begin
                        state_q      <= BUSY_D;
                        last_grant_q <= GRANT_MEM;
                        sel_q        <= 1'b1;
                        valid_q      <= 1'b1;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                        wd_cnt_q     <= '0;
`endif
                    end else if (grant_if) begin
                        state_q      <= BUSY_I;
                        last_grant_q <= GRANT_IF;
                        sel_q        <= 1'b0;
                        valid_q      <= 1'b1;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                        wd_cnt_q     <= '0;
`endif
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (port_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end else begin
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                        if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                            state_q <= ERR;
                            valid_q <= 1'b0;
                            err_q   <= 1'b1;
                        end
                        wd_cnt_q <= wd_cnt_q + 1'b1;
`endif
                    end
                end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                ERR: begin
                    state_q <= ERR;
                end
`endif
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are forced low while reset is asserted so an aborted access
    // never produces a done pulse; data/address paths stay pass-through.
    assign port_sel   = sel_q & ~rst;
    assign port_valid = valid_q & ~rst;
    assign port_we    = busy_d & mem_we & ~rst;
    assign port_addr  = sel_q ? mem_addr : if_addr;
    assign port_wdata = mem_wdata;
    assign if_done    = busy_i & port_ready & ~rst;
    assign mem_done   = busy_d & port_ready & ~rst;
    assign rd_data    = port_rdata;
    assign stall_if   = if_req & ~if_done & ~rst;
    assign stall_mem  = mem_req & ~mem_done & ~rst;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    assign err        = err_q & ~rst;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected completions,
// a monitor pops and compares on every done pulse.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        port_ready;
    logic [31:0] port_rdata;
    logic        port_sel;
    logic        port_valid;
    logic        port_we;
    logic [31:0] port_addr;
    logic [31:0] port_wdata;
    logic        if_done;
    logic        mem_done;
    logic [31:0] rd_data;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .port_ready (port_ready),
        .port_rdata (port_rdata),
        .port_sel   (port_sel),
        .port_valid (port_valid),
        .port_we    (port_we),
        .port_addr  (port_addr),
        .port_wdata (port_wdata),
        .if_done    (if_done),
        .mem_done   (mem_done),
        .rd_data    (rd_data),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem),
        .err        (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_mem;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic is_mem, input logic [31:0] addr, input logic we,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int dcyc);
        expq.push_back('{is_mem, addr, we, wdata, rdata, cyc + dcyc});
    endtask

    // Advance to just after the next rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (if_done === 1'b1 || mem_done === 1'b1) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got if_done=%b mem_done=%b at cycle %0d expected none",
                         if_done, mem_done, cyc);
            end else begin
                mon_e = expq.pop_front();
                chk("done_which", {30'b0, if_done, mem_done}, mon_e.is_mem ? 32'd1 : 32'd2);
                chk("done_cycle", cyc, mon_e.cyc);
                chk("done_addr", port_addr, mon_e.addr);
                chk("done_we", {31'b0, port_we}, {31'b0, mon_e.we});
                if (mon_e.is_mem && mon_e.we) chk("done_wdata", port_wdata, mon_e.wdata);
                chk("done_rdata", rd_data, mon_e.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish expected finish before 100000");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst        = 1'b1;
        if_req     = 1'b1;
        if_addr    = 32'h0000_0040;
        mem_req    = 1'b1;
        mem_we     = 1'b0;
        mem_addr   = 32'h0000_0200;
        mem_wdata  = 32'h5555_AAAA;
        port_ready = 1'b1;
        port_rdata = 32'h1111_1111;

        // Reset held with requests pending: only passthroughs may be non-zero.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, port_valid}, 32'd0);
        chk("rst_sel", {31'b0, port_sel}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_stall", {30'b0, stall_if, stall_mem}, 32'd0);
        chk("rst_we", {31'b0, port_we}, 32'd0);
        chk("rst_rdata_pass", rd_data, 32'h1111_1111);
        chk("rst_addr_pass", port_addr, 32'h0000_0040);
        chk("rst_wdata_pass", port_wdata, 32'h5555_AAAA);

        // Contention straight after reset: MEM first, one IDLE, then IF.
        next();
        rst = 1'b0;
        push(1'b1, 32'h0000_0200, 1'b0, 32'h0, 32'h1111_1111, 1);
        push(1'b0, 32'h0000_0040, 1'b0, 32'h0, 32'h1111_1111, 3);
        @(negedge clk);
        chk("cont_c0_valid", {31'b0, port_valid}, 32'd0);
        chk("cont_c0_stall", {30'b0, stall_if, stall_mem}, 32'd3);
        next();
        @(negedge clk);
        chk("cont_c1_sel", {31'b0, port_sel}, 32'd1);
        chk("cont_c1_valid", {31'b0, port_valid}, 32'd1);
        chk("cont_c1_stall", {30'b0, stall_if, stall_mem}, 32'd2);
        next();
        mem_req = 1'b0;
        @(negedge clk);
        chk("cont_c2_idle", {31'b0, port_valid}, 32'd0);
        next();
        @(negedge clk);
        chk("cont_c3_sel", {31'b0, port_sel}, 32'd0);
        chk("cont_c3_valid", {31'b0, port_valid}, 32'd1);
        next();
        if_req = 1'b0;
        repeat (2) next();

        // Single fetch.
        if_req     = 1'b1;
        if_addr    = 32'h0000_0040;
        port_rdata = 32'hDEAD_BEEF;
        push(1'b0, 32'h0000_0040, 1'b0, 32'h0, 32'hDEAD_BEEF, 1);
        next();
        @(negedge clk);
        chk("fetch_sel", {31'b0, port_sel}, 32'd0);
        chk("fetch_valid", {31'b0, port_valid}, 32'd1);
        chk("fetch_stall_if", {31'b0, stall_if}, 32'd0);
        next();
        if_req = 1'b0;
        repeat (2) next();

        // Write with three wait states.
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = 32'h0000_0100;
        mem_wdata  = 32'h1234_5678;
        port_ready = 1'b0;
        port_rdata = 32'h0BAD_F00D;
        push(1'b1, 32'h0000_0100, 1'b1, 32'h1234_5678, 32'h0BAD_F00D, 4);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) port_ready = 1'b0;
            @(negedge clk);
            chk("wr_stall_mem", {31'b0, stall_mem}, 32'd1);
            if (i > 0) begin
                chk("wr_we", {31'b0, port_we}, 32'd1);
                chk("wr_valid", {31'b0, port_valid}, 32'd1);
            end
            next();
        end
        port_ready = 1'b1;
        @(negedge clk);
        chk("wr_c4_stall_mem", {31'b0, stall_mem}, 32'd0);
        next();
        mem_req = 1'b0;
        mem_we  = 1'b0;
        repeat (2) next();

        // Round robin: MEM had the last grant, so IF wins this contention.
        if_req     = 1'b1;
        if_addr    = 32'h0000_0080;
        mem_req    = 1'b1;
        mem_addr   = 32'h0000_0300;
        port_rdata = 32'h2222_2222;
        push(1'b0, 32'h0000_0080, 1'b0, 32'h0, 32'h2222_2222, 1);
        push(1'b1, 32'h0000_0300, 1'b0, 32'h0, 32'h2222_2222, 3);
        next();
        next();
        if_req = 1'b0;
        next();
        next();
        mem_req = 1'b0;
        repeat (2) next();

        // Reset in the middle of a BUSY_D write, then contention afterwards.
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = 32'h0000_0400;
        mem_wdata  = 32'hCAFE_0001;
        port_ready = 1'b0;
        port_rdata = 32'h3333_3333;
        next();
        @(negedge clk);
        chk("mid_busy_sel", {31'b0, port_sel}, 32'd1);
        next();
        rst        = 1'b1;
        port_ready = 1'b1;
        if_req     = 1'b1;
        if_addr    = 32'h0000_0500;
        @(negedge clk);
        chk("mid_rst_done", {30'b0, if_done, mem_done}, 32'd0);
        chk("mid_rst_valid", {31'b0, port_valid}, 32'd0);
        chk("mid_rst_stall", {30'b0, stall_if, stall_mem}, 32'd0);
        next();
        rst = 1'b0;
        push(1'b1, 32'h0000_0400, 1'b1, 32'hCAFE_0001, 32'h3333_3333, 1);
        push(1'b0, 32'h0000_0500, 1'b0, 32'h0, 32'h3333_3333, 3);
        @(negedge clk);
        chk("post_rst_valid", {31'b0, port_valid}, 32'd0);
        next();
        @(negedge clk);
        chk("post_rst_mem_first", {31'b0, port_sel}, 32'd1);
        next();
        mem_req = 1'b0;
        mem_we  = 1'b0;
        next();
        next();
        if_req = 1'b0;
        repeat (2) next();

        // Watchdog: fetch granted, memory never ready.
        if_req     = 1'b1;
        if_addr    = 32'h0000_00C0;
        port_ready = 1'b0;
        repeat (4) next();
        @(negedge clk);
        chk("wd_c4_valid", {31'b0, port_valid}, 32'd1);
        chk("wd_c4_err", {31'b0, err}, 32'd0);
        next();
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        @(negedge clk);
        chk("wd_err_set", {31'b0, err}, 32'd1);
        chk("wd_err_valid", {31'b0, port_valid}, 32'd0);
        chk("wd_err_stall_if", {31'b0, stall_if}, 32'd1);
        next();
        if_req     = 1'b0;
        mem_req    = 1'b1;
        port_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wd_no_grant", {31'b0, port_valid}, 32'd0);
            chk("wd_err_sticky", {31'b0, err}, 32'd1);
            chk("wd_stall_mem", {31'b0, stall_mem}, 32'd1);
            next();
        end
`else
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wd_off_valid", {31'b0, port_valid}, 32'd1);
            chk("wd_off_err", {31'b0, err}, 32'd0);
            next();
        end
`endif
        rst     = 1'b1;
        if_req  = 1'b0;
        mem_req = 1'b0;
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("wd_after_rst_err", {31'b0, err}, 32'd0);
        chk("wd_after_rst_valid", {31'b0, port_valid}, 32'd0);
        next();

        // Every expected completion must have been observed.
        for (int i = 0; i < 20 && expq.size() != 0; i++) next();
        chk("scoreboard_drained", expq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
